// File: rtl/feed_forward_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and the layer instances it drives.
//   i_start       : begin a pass at layer 0 (sampled only while idle)
//   i_abort       : terminate the current pass
//   i_layer_done  : per-layer completion pulses (layer o_valid)
//   o_layer_start : one-hot start pulse (layer i_valid)
//   o_layer_idx   : layer currently launched/awaited
//   o_busy        : pass in progress
//   o_done        : one-cycle pulse when the last layer completes
//   o_error       : sticky watchdog timeout flag
//   o_error_layer : layer that timed out, valid while o_error is high
// The master modport is the sequencer; the slave modport is its environment.
interface feed_forward_layer_sequencer_if #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned IDX_WIDTH  = 2
);
  logic                  i_start;
  logic                  i_abort;
  logic [NUM_LAYERS-1:0] i_layer_done;
  logic [NUM_LAYERS-1:0] o_layer_start;
  logic [IDX_WIDTH-1:0]  o_layer_idx;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;
  logic [IDX_WIDTH-1:0]  o_error_layer;

  modport master (
    input  i_start,
    input  i_abort,
    input  i_layer_done,
    output o_layer_start,
    output o_layer_idx,
    output o_busy,
    output o_done,
    output o_error,
    output o_error_layer
  );

  modport slave (
    output i_start,
    output i_abort,
    output i_layer_done,
    input  o_layer_start,
    input  o_layer_idx,
    input  o_busy,
    input  o_done,
    input  o_error,
    input  o_error_layer
  );
endinterface

// File: rtl/feed_forward_layer_sequencer.sv
// Launches the layers of one feed-forward net in order (layer 0 first), waiting for each
// layer's done pulse, inserting GAP_CYCLES settle cycles between layers, and guarding each
// layer with a TIMEOUT_CYCLES watchdog.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : handshake bundle (master side), see feed_forward_layer_sequencer_if
// All outputs are registered or decoded from registered state.
module feed_forward_layer_sequencer #(
  parameter int unsigned NUM_LAYERS     = 3,
  parameter int unsigned IDX_WIDTH      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TIMER_WIDTH    = 16,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input logic                          clk,
  input logic                          rst_n,
  feed_forward_layer_sequencer_if.master bus
);

  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [TIMER_WIDTH-1:0] TimerLast = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0]        GapCntLast = GapW'(GapLast);
  localparam logic [IDX_WIDTH-1:0]   IdxLast   = IDX_WIDTH'(NUM_LAYERS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLaunch = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;
  localparam logic [2:0] StError  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic                   err_q, err_d;
  logic [IDX_WIDTH-1:0]   err_layer_q, err_layer_d;
  logic [NUM_LAYERS-1:0]  layer_start;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    err_d       = err_q;
    err_layer_d = err_layer_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d     = StLaunch;
          idx_d       = '0;
          err_d       = 1'b0;
          err_layer_d = '0;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Saturating so a missed exit can never wrap back into the allowed window.
        if (timer_q != TimerLast) begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
        // Done is tested first so a completion on the last allowed cycle still succeeds.
        if (bus.i_layer_done[idx_q]) begin
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else if (GAP_CYCLES == 0) begin
            state_d = StLaunch;
            idx_d   = idx_q + IDX_WIDTH'(1);
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end else if (timer_q == TimerLast) begin
          state_d = StError;
        end
      end
      StGap: begin
        if (gap_q == GapCntLast) begin
          state_d = StLaunch;
          idx_d   = idx_q + IDX_WIDTH'(1);
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StError: begin
        state_d     = StIdle;
        err_d       = 1'b1;
        err_layer_d = idx_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort beats everything, including a pending error latch and the next launch.
    if (bus.i_abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      idx_d       = idx_q;
      err_d       = err_q;
      err_layer_d = err_layer_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      err_q       <= 1'b0;
      err_layer_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      err_layer_q <= err_layer_d;
    end
  end

  always_comb begin
    layer_start = '0;
    if (state_q == StLaunch) begin
      layer_start[idx_q] = 1'b1;
    end
  end

  assign bus.o_layer_start = layer_start;
  assign bus.o_layer_idx   = idx_q;
  assign bus.o_busy        = (state_q != StIdle);
  assign bus.o_done        = (state_q == StDone);
  assign bus.o_error       = err_q;
  assign bus.o_error_layer = err_layer_q;

endmodule

// File: tb/tb_feed_forward_layer_sequencer.sv
// Three sequencers with different watchdog/gap settings, each driven by directed and
// randomized passes. Expected outputs come from an event-timeline model: launch, done,
// error and idle cycles are computed from the layer delays, then decoded per cycle.
module tb_feed_forward_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_v  [3];
  logic       start_v [3];
  logic       abort_v [3];
  logic [2:0] done_v  [3];
  logic [9:0] obs     [3];  // {start[2:0], busy, done, error, error_layer[1:0], idx[1:0]}

  feed_forward_layer_sequencer_if #(.NUM_LAYERS(3), .IDX_WIDTH(2)) bus0 ();
  feed_forward_layer_sequencer_if #(.NUM_LAYERS(3), .IDX_WIDTH(2)) bus1 ();
  feed_forward_layer_sequencer_if #(.NUM_LAYERS(3), .IDX_WIDTH(2)) bus2 ();

  assign bus0.i_start = start_v[0];
  assign bus0.i_abort = abort_v[0];
  assign bus0.i_layer_done = done_v[0];
  assign bus1.i_start = start_v[1];
  assign bus1.i_abort = abort_v[1];
  assign bus1.i_layer_done = done_v[1];
  assign bus2.i_start = start_v[2];
  assign bus2.i_abort = abort_v[2];
  assign bus2.i_layer_done = done_v[2];

  assign obs[0] = {bus0.o_layer_start, bus0.o_busy, bus0.o_done, bus0.o_error,
                   bus0.o_error_layer, bus0.o_layer_idx};
  assign obs[1] = {bus1.o_layer_start, bus1.o_busy, bus1.o_done, bus1.o_error,
                   bus1.o_error_layer, bus1.o_layer_idx};
  assign obs[2] = {bus2.o_layer_start, bus2.o_busy, bus2.o_done, bus2.o_error,
                   bus2.o_error_layer, bus2.o_layer_idx};

  feed_forward_layer_sequencer #(
    .NUM_LAYERS(3), .IDX_WIDTH(2), .TIMEOUT_CYCLES(4096), .TIMER_WIDTH(16), .GAP_CYCLES(2)
  ) u_seq0 (.clk(clk), .rst_n(rstn_v[0]), .bus(bus0));

  feed_forward_layer_sequencer #(
    .NUM_LAYERS(3), .IDX_WIDTH(2), .TIMEOUT_CYCLES(8), .TIMER_WIDTH(3), .GAP_CYCLES(2)
  ) u_seq1 (.clk(clk), .rst_n(rstn_v[1]), .bus(bus1));

  feed_forward_layer_sequencer #(
    .NUM_LAYERS(3), .IDX_WIDTH(2), .TIMEOUT_CYCLES(16), .TIMER_WIDTH(4), .GAP_CYCLES(0)
  ) u_seq2 (.clk(clk), .rst_n(rstn_v[2]), .bus(bus2));

  int tmo_of [3] = '{4096, 8, 16};
  int gap_of [3] = '{2, 2, 0};

  int n_vec  = 0;
  int n_miss = 0;

  // Idle-side state carried between passes.
  logic       prev_err  [3];
  logic [1:0] prev_errl [3];
  logic [1:0] prev_idx  [3];

  // Timeline of the current pass, cycle 0 = the cycle i_start is driven.
  int dly [3];
  int lcyc [3];
  int n_launch, done_cyc, err_cyc, err_k, end_c, end_eff, abort_at;

  localparam int Never = 1 << 30;

  task automatic check_vec(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic void plan(input int u);
    int cyc;
    cyc      = 1;
    done_cyc = -1;
    err_cyc  = -1;
    err_k    = 0;
    n_launch = 0;
    for (int k = 0; k < 3; k++) begin
      lcyc[k]  = cyc;
      n_launch = k + 1;
      if (dly[k] == 0 || dly[k] > tmo_of[u]) begin
        err_cyc = cyc + tmo_of[u] + 1;
        err_k   = k;
        break;
      end
      if (k == 2) done_cyc = cyc + dly[k] + 1;
      else cyc = cyc + dly[k] + 1 + gap_of[u];
    end
    end_c = (done_cyc >= 0) ? done_cyc : err_cyc;
  endfunction

  // Layer whose launch most recently occurred at or before cycle c.
  function automatic int layer_at(input int c);
    int w;
    w = 0;
    for (int k = 0; k < n_launch; k++) if (lcyc[k] <= c) w = k;
    return w;
  endfunction

  function automatic logic [9:0] exp_vec(input int u, input int c);
    logic [2:0] st;
    logic       b, d, e, err_set;
    logic [1:0] el, ix;
    st = '0;
    for (int k = 0; k < n_launch; k++) if (lcyc[k] == c && lcyc[k] <= abort_at) st[k] = 1'b1;
    b = (c >= 1) && (c <= end_eff);
    d = (done_cyc >= 0) && (c == done_cyc) && (done_cyc <= abort_at);
    err_set = (err_cyc >= 0) && (err_cyc < abort_at);
    if (c == 0) begin
      e  = prev_err[u];
      el = prev_errl[u];
      ix = prev_idx[u];
    end else begin
      e  = err_set && (c > err_cyc);
      el = e ? 2'(err_k) : 2'd0;
      ix = 2'(layer_at((c < end_eff) ? c : end_eff));
    end
    return {st, b, d, e, el, ix};
  endfunction

  // abort_req: -1 none, -2 random cycle inside the pass, otherwise that cycle.
  task automatic run_pass(input int u, input int d0, input int d1, input int d2,
                          input int abort_req, input bit spur, input bit bstart);
    logic [2:0] dv;
    logic [9:0] v;
    int         a, w;
    dly[0] = d0;
    dly[1] = d1;
    dly[2] = d2;
    plan(u);
    a = (abort_req == -2) ? int'($urandom_range(1, end_c)) : abort_req;
    abort_at = (a >= 1 && a <= end_c) ? a : Never;
    end_eff  = (end_c < abort_at) ? end_c : abort_at;
    for (int c = 0; c <= end_eff + 2; c++) begin
      @(posedge clk);
      #1;
      start_v[u] = (c == 0) ||
                   (bstart && c >= 1 && c <= end_eff && $urandom_range(0, 2) == 0);
      abort_v[u] = (c == abort_at);
      dv = '0;
      for (int k = 0; k < n_launch; k++) if (dly[k] != 0 && c == lcyc[k] + dly[k]) dv[k] = 1'b1;
      if (spur && c >= 1 && c <= end_eff) begin
        w = layer_at(c);
        for (int j = 0; j < 3; j++) if (j != w && $urandom_range(0, 2) == 0) dv[j] = 1'b1;
      end
      done_v[u] = dv;
      @(negedge clk);
      check_vec($sformatf("u%0d_c%0d", u, c), obs[u], exp_vec(u, c));
    end
    v = exp_vec(u, end_eff + 2);
    prev_err[u]  = v[4];
    prev_errl[u] = v[3:2];
    prev_idx[u]  = v[1:0];
    start_v[u] = 1'b0;
    abort_v[u] = 1'b0;
    done_v[u]  = '0;
  endtask

  task automatic run_random(input int u, input int n);
    int hi;
    int d [3];
    hi = (u == 0) ? 20 : tmo_of[u] + 2;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        d[k] = (u != 0 && $urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, hi));
      end
      run_pass(u, d[0], d[1], d[2], ($urandom_range(0, 4) == 0) ? -2 : -1,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rstn_v[u]    = 1'b0;
      start_v[u]   = 1'b0;
      abort_v[u]   = 1'b0;
      done_v[u]    = '0;
      prev_err[u]  = 1'b0;
      prev_errl[u] = '0;
      prev_idx[u]  = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) check_vec($sformatf("reset_u%0d", u), obs[u], 10'b0);
    for (int u = 0; u < 3; u++) rstn_v[u] = 1'b1;

    // Nominal: starts 1/14/27, done 38, idle from 39.
    run_pass(0, 10, 10, 10, -1, 1'b0, 1'b0);
    // Spurious done bits and start while busy: same timeline.
    run_pass(0, 10, 10, 10, -1, 1'b1, 1'b1);
    // Abort in the gap after layer 0.
    run_pass(0, 10, 10, 10, 12, 1'b0, 1'b0);
    run_random(0, 20);

    // Timeout on layer 1, then a clean pass clears the error.
    run_pass(1, 3, 0, 5, -1, 1'b0, 1'b0);
    run_pass(1, 2, 2, 2, -1, 1'b0, 1'b0);
    // Done on the last allowed WAIT cycle, then one cycle too late.
    run_pass(1, 8, 8, 8, -1, 1'b0, 1'b0);
    run_pass(1, 8, 8, 9, -1, 1'b0, 1'b0);
    run_random(1, 30);

    // No gap, instant done: launches two cycles apart.
    run_pass(2, 1, 1, 1, -1, 1'b0, 1'b0);
    run_random(2, 30);

    // Asynchronous reset while waiting on layer 0.
    @(posedge clk);
    #1 start_v[2] = 1'b1;
    @(posedge clk);
    #1 start_v[2] = 1'b0;
    @(posedge clk);
    #1 check_vec("pre_reset_wait", obs[2], {3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});
    #2 rstn_v[2] = 1'b0;
    #1 check_vec("async_reset", obs[2], 10'b0);
    @(negedge clk);
    rstn_v[2]    = 1'b1;
    prev_err[2]  = 1'b0;
    prev_errl[2] = '0;
    prev_idx[2]  = '0;
    run_pass(2, 3, 1, 2, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
